// File: rtl/stream_mux_rr_if.sv
// Stream mux handshake bundle: CHANNELS input streams in, one tagged stream out.
// The slave modport is the mux's view; master is the driver/consumer side.
interface stream_mux_rr_if #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
);
  localparam int SEL_W = (CHANNELS > 2) ? $clog2(CHANNELS) : 1;

  logic [CHANNELS*WIDTH-1:0] in_data;
  logic [CHANNELS-1:0]       in_valid;
  logic [CHANNELS-1:0]       in_ready;
  logic [SEL_W-1:0]          sel;
  logic [WIDTH-1:0]          out_data;
  logic                      out_valid;
  logic                      out_ready;
  logic [SEL_W-1:0]          out_chan;

  modport master (
    output in_data, in_valid, sel, out_ready,
    input  in_ready, out_data, out_valid, out_chan
  );

  modport slave (
    input  in_data, in_valid, sel, out_ready,
    output in_ready, out_data, out_valid, out_chan
  );
endinterface

// File: rtl/stream_mux_rr.sv
// N:1 stream mux with registered output, select-driven (MODE=0) or round-robin (MODE=1).
// Define STREAM_MUX_STATS_EN to add the 16-bit output handshake counter xfer_count.
module stream_mux_rr #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int MODE     = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  stream_mux_rr_if.slave    bus
`ifdef STREAM_MUX_STATS_EN
  ,
  output logic [15:0]       xfer_count
`endif
);
  localparam int SEL_W = (CHANNELS > 2) ? $clog2(CHANNELS) : 1;
  localparam int VLD_W = 1 << SEL_W;

  logic [1:0]                     rst_pipe;
  logic                           rst_ok;
  logic [CHANNELS-1:0][WIDTH-1:0] ch_data;
  logic [VLD_W-1:0]               vld_ext;
  logic [SEL_W-1:0]               ptr;
  logic [SEL_W-1:0]               gnt;
  logic                           gnt_vld;
  logic                           load_en;
  logic [CHANNELS-1:0]            ready;
  logic [WIDTH-1:0]               data_q;
  logic [SEL_W-1:0]               chan_q;
  logic                           valid_q;

  // Reset asserts asynchronously but its release is retimed to clk before loads are allowed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_pipe <= 2'b00;
    else        rst_pipe <= {rst_pipe[0], 1'b1};
  end
  assign rst_ok = rst_pipe[1];

  assign ch_data = bus.in_data;
  // Padding to a power of two makes out-of-range indices read as "not valid".
  assign vld_ext = VLD_W'(bus.in_valid);
  assign load_en = rst_ok && (!valid_q || bus.out_ready);

  always_comb begin
    int               idx;
    logic [SEL_W-1:0] idx_s;
    gnt     = '0;
    gnt_vld = 1'b0;
    idx     = 0;
    idx_s   = '0;
    if (MODE == 0) begin
      gnt     = bus.sel;
      gnt_vld = vld_ext[bus.sel];
    end else begin
      // Walk from farthest to nearest so the first valid after ptr wins.
      for (int k = CHANNELS; k >= 1; k--) begin
        idx = int'(ptr) + k;
        if (idx >= CHANNELS) idx = idx - CHANNELS;
        idx_s = SEL_W'(idx);
        if (vld_ext[idx_s]) begin
          gnt     = idx_s;
          gnt_vld = 1'b1;
        end
      end
    end
  end

  always_comb begin
    ready = '0;
    if (gnt_vld && load_en) ready[gnt] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      chan_q  <= '0;
      valid_q <= 1'b0;
      ptr     <= SEL_W'(CHANNELS - 1);
    end else if (load_en) begin
      if (gnt_vld) begin
        data_q  <= ch_data[gnt];
        chan_q  <= gnt;
        valid_q <= 1'b1;
        ptr     <= gnt;
      end else begin
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = ready;
  assign bus.out_data  = data_q;
  assign bus.out_chan  = chan_q;
  assign bus.out_valid = valid_q;

`ifdef STREAM_MUX_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        xfer_count <= '0;
    else if (valid_q && bus.out_ready) xfer_count <= xfer_count + 16'd1;
  end
`endif
endmodule

// File: doc/stream_mux_rr.md
STREAM_MUX_RR -- requirements
Module: stream_mux_rr

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data width per channel in bits.
REQ-002 SHALL have parameter CHANNELS, default 4: input channel count, 2..16.
REQ-003 SHALL have parameter MODE, default 1: 0 = select-driven, 1 = round-robin arbitration.
REQ-004 SHALL have localparam SEL_W = clog2(CHANNELS), minimum 1.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 in_data  input  CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
REQ-008 in_valid  input  CHANNELS  per-channel valid.
REQ-009 in_ready  output  CHANNELS  per-channel ready; at most one bit high per cycle.
REQ-010 sel  input  SEL_W  channel select, used only when MODE=0.
REQ-011 out_data  output  WIDTH  registered output data.
REQ-012 out_valid  output  1  output register holds a word.
REQ-013 out_ready  input  1  downstream accepts the word.
REQ-014 out_chan  output  SEL_W  source channel index of out_data.

Function
REQ-015 The output register SHALL be able to load when out_valid=0, or when out_valid=1 and out_ready=1 in the same cycle (load_en).
REQ-016 MODE=0: grant SHALL be channel sel when sel<CHANNELS and in_valid[sel]=1; otherwise there SHALL be no grant. sel>=CHANNELS yields no grant.
REQ-017 MODE=1: grant SHALL be the first channel with in_valid=1, searching from ptr+1 upward modulo CHANNELS. ptr is the last granted channel.
REQ-018 ptr SHALL update to the granted index only on an accepted input transfer (load_en and grant); it is otherwise held.
REQ-019 in_ready[g] SHALL equal load_en for granted channel g; all other in_ready bits SHALL be 0. in_ready is combinational from current state and inputs.
REQ-020 On an input transfer, out_data, out_chan and out_valid=1 SHALL load on the next edge. Latency from input handshake to out_valid is 1 cycle.
REQ-021 If out_valid=1 and out_ready=1 with no grant, out_valid SHALL clear on the next edge.
REQ-022 Simultaneous consume and load SHALL sustain 1 word per cycle with no bubble.
REQ-023 While out_valid=1 and out_ready=0, out_data, out_chan and ptr SHALL be held and all in_ready SHALL be 0.
REQ-024 Round-robin wrap: after channel CHANNELS-1 is granted, the search SHALL start at channel 0.
REQ-025 Changes of in_valid or sel while stalled SHALL have no effect until load_en=1.

Reset
REQ-026 On rst_n=0, the block SHALL immediately set out_valid=0, out_data=0, out_chan=0 and ptr=CHANNELS-1, so that the first round-robin grant is channel 0.
REQ-027 While rst_n=0, all in_ready SHALL be 0. A word in flight at reset assertion SHALL be discarded.
REQ-028 Reset release SHALL be synchronous to clk. The first load SHALL occur no earlier than the first rising edge after deassertion.

Configuration
REQ-029 Macro STREAM_MUX_STATS_EN defined: the block SHALL add output xfer_count [15:0]. It counts output handshakes (out_valid and out_ready), wraps from 0xFFFF to 0, and resets to 0.
REQ-030 Macro STREAM_MUX_STATS_EN undefined: the xfer_count port and its logic SHALL be absent, with all other behaviour identical.

Verification
REQ-031 MODE=1, all 4 channels valid, out_ready=1 constantly -> out_chan sequence 0,1,2,3,0 on consecutive cycles with no gap.
REQ-032 MODE=1, only ch2 valid with data 0xA5 -> out_data=0xA5, out_chan=2 one cycle after in_ready[2]=1; ptr=2, so a later ch1+ch3 request grants ch3 first.
REQ-033 MODE=0, sel=1, in_valid=4'b0011, ch1 data 0x3C -> only in_ready[1]=1; out_data=0x3C; ch0 is never granted.
REQ-034 out_valid=1, out_ready held 0 for 5 cycles while inputs change -> out_data/out_chan stable and in_ready=0; on release, the next word follows with no loss or duplicate.
REQ-035 Assert rst_n=0 mid-stream with out_valid=1 -> out_valid=0 immediately; after release with all valid, the first grant is ch0.
REQ-036 With STREAM_MUX_STATS_EN, 70000 handshakes -> xfer_count=70000 mod 65536=4464.
